// File: rtl/icache_line_fill_pkg.sv
// Shared types and constants for the I-cache line-fill engine and its AHB-lite burst port.
package icache_line_fill_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned WORD_BITS  = 32;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'b000,
        BURST_INCR   = 3'b001,
        BURST_WRAP4  = 3'b010,
        BURST_INCR4  = 3'b011
    } hburst_t;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_LAST,
        S_RESP
    } fill_state_t;

    // Word index of beat `beat` in a WRAP4 burst starting at word `start`; wraps inside the line.
    function automatic logic [1:0] wrap4_word(input logic [1:0] start, input logic [1:0] beat);
        return start + beat;
    endfunction

endpackage

// File: rtl/icache_line_fill_if.sv
// Miss-request, fill-return and AHB-lite master signals of the line-fill engine.
interface icache_line_fill_if
    import icache_line_fill_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_BITS = 128
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic                  fill_valid;
    logic                  fill_err;
    logic [ADDR_W-1:0]     fill_addr;
    logic [LINE_BITS-1:0]  fill_line;
    logic                  crit_valid;
    logic [WORD_BITS-1:0]  crit_data;
    logic [ADDR_W-1:0]     haddr;
    logic [1:0]            htrans;
    logic [2:0]            hburst;
    logic [2:0]            hsize;
    logic                  hwrite;
    logic                  hready;
    logic                  hresp;
    logic [WORD_BITS-1:0]  hrdata;

    modport master (
        input  req_valid, req_addr, hready, hresp, hrdata,
        output req_ready, fill_valid, fill_err, fill_addr, fill_line,
               crit_valid, crit_data, haddr, htrans, hburst, hsize, hwrite
    );

    modport slave (
        output req_valid, req_addr, hready, hresp, hrdata,
        input  req_ready, fill_valid, fill_err, fill_addr, fill_line,
               crit_valid, crit_data, haddr, htrans, hburst, hsize, hwrite
    );

endinterface

// File: rtl/icache_line_fill_wrap4_addr_gen.sv
// Combinational WRAP4 beat address: line bits kept, word index wraps mod 4, byte offset zeroed.
module wrap4_addr_gen
    import icache_line_fill_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [1:0]        beat,
    output logic [ADDR_W-1:0] addr
);

    logic unused_base_lsbs;
    assign unused_base_lsbs = ^base[1:0];

    assign addr = {base[ADDR_W-1:4], wrap4_word(base[3:2], beat), 2'b00};

endmodule

// File: rtl/icache_line_fill.sv
// I-cache line-fill engine: one miss -> 4-beat AHB WRAP4 read -> 128-bit line with a completion pulse.
// Optional critical-word forwarding is enabled by defining LINE_FILL_CWF_EN.
module icache_line_fill
    import icache_line_fill_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_BITS = 128
) (
    input logic                clk,
    input logic                rst,
    icache_line_fill_if.master bus
);

    if (LINE_BITS != LINE_WORDS * WORD_BITS) begin : g_line_bits_check
        $error("icache_line_fill: LINE_BITS must be 128 (4 x 32-bit beats)");
    end

    fill_state_t          state;
    logic [ADDR_W-1:0]    base_addr;
    logic [ADDR_W-1:0]    haddr_q;
    htrans_t              htrans_q;
    hburst_t              hburst_q;
    logic [1:0]           acnt;
    logic [1:0]           dcnt;
    logic                 err_q;
    logic [LINE_BITS-1:0] line_buf;
    logic [LINE_BITS-1:0] line_next;
    logic [LINE_BITS-1:0] fill_line_q;
    logic [ADDR_W-1:0]    fill_addr_q;
    logic                 fill_valid_q;
    logic                 fill_err_q;

    logic [ADDR_W-1:0]    gen_base;
    logic [1:0]           gen_beat;
    logic [ADDR_W-1:0]    next_addr;
    logic [ADDR_W-1:0]    data_addr;
    logic [ADDR_W-1:0]    line_base;
    logic                 capture;
    logic                 unused_data_addr;

    // In IDLE the generator previews beat 0 of the incoming request; otherwise the beat after acnt.
    always_comb begin
        gen_base = base_addr;
        gen_beat = acnt + 2'd1;
        if (state == S_IDLE) begin
            gen_base = bus.req_addr;
            gen_beat = 2'd0;
        end
    end

    wrap4_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .base (gen_base),
        .beat (gen_beat),
        .addr (next_addr)
    );

    wrap4_addr_gen #(.ADDR_W(ADDR_W)) u_data_gen (
        .base (base_addr),
        .beat (dcnt),
        .addr (data_addr)
    );

    assign unused_data_addr = ^{data_addr[ADDR_W-1:4], data_addr[1:0]};
    assign line_base        = {base_addr[ADDR_W-1:4], 4'b0000};

    // A data phase completes cleanly only in BURST/LAST with OKAY and no ERROR already seen.
    assign capture = ((state == S_BURST) || (state == S_LAST)) &&
                     bus.hready && !bus.hresp && !err_q;

    always_comb begin
        line_next = line_buf;
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            if (data_addr[3:2] == 2'(w)) begin
                line_next[w*WORD_BITS +: WORD_BITS] = bus.hrdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            base_addr    <= '0;
            haddr_q      <= '0;
            htrans_q     <= TRANS_IDLE;
            hburst_q     <= BURST_SINGLE;
            acnt         <= '0;
            dcnt         <= '0;
            err_q        <= 1'b0;
            line_buf     <= '0;
            fill_line_q  <= '0;
            fill_addr_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
        end else begin
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            if (capture) begin
                line_buf <= line_next;
            end
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        base_addr <= bus.req_addr;
                        haddr_q   <= next_addr;
                        htrans_q  <= TRANS_NONSEQ;
                        hburst_q  <= BURST_WRAP4;
                        acnt      <= '0;
                        dcnt      <= '0;
                        err_q     <= 1'b0;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.hready) begin
                        acnt     <= 2'd1;
                        haddr_q  <= next_addr;
                        htrans_q <= TRANS_SEQ;
                        state    <= S_BURST;
                    end
                end
                S_BURST: begin
                    // First ERROR cycle idles the bus; the second completes the fill as failed.
                    if (bus.hresp) begin
                        htrans_q <= TRANS_IDLE;
                        hburst_q <= BURST_SINGLE;
                        if (bus.hready) begin
                            fill_valid_q <= 1'b1;
                            fill_err_q   <= 1'b1;
                            fill_addr_q  <= line_base;
                            state        <= S_RESP;
                        end else begin
                            err_q <= 1'b1;
                            state <= S_LAST;
                        end
                    end else if (bus.hready) begin
                        dcnt <= dcnt + 2'd1;
                        if (acnt == 2'd3) begin
                            htrans_q <= TRANS_IDLE;
                            hburst_q <= BURST_SINGLE;
                            state    <= S_LAST;
                        end else begin
                            acnt    <= acnt + 2'd1;
                            haddr_q <= next_addr;
                        end
                    end
                end
                S_LAST: begin
                    if (bus.hready) begin
                        fill_valid_q <= 1'b1;
                        fill_addr_q  <= line_base;
                        state        <= S_RESP;
                        if (bus.hresp || err_q) begin
                            fill_err_q <= 1'b1;
                        end else begin
                            fill_line_q <= line_next;
                        end
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LINE_FILL_CWF_EN
    logic                 crit_valid_q;
    logic [WORD_BITS-1:0] crit_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            crit_valid_q <= capture && (dcnt == 2'd0);
            if (capture && (dcnt == 2'd0)) begin
                crit_data_q <= bus.hrdata;
            end
        end
    end

    assign bus.crit_valid = crit_valid_q;
    assign bus.crit_data  = crit_data_q;
`else
    assign bus.crit_valid = 1'b0;
    assign bus.crit_data  = '0;
`endif

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_err   = fill_err_q;
    assign bus.fill_addr  = fill_addr_q;
    assign bus.fill_line  = fill_line_q;
    assign bus.haddr      = haddr_q;
    assign bus.htrans     = htrans_q;
    assign bus.hburst     = hburst_q;
    assign bus.hsize      = HSIZE_WORD;
    assign bus.hwrite     = 1'b0;

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill: zero-wait, wait states, ERROR, mid-burst reset, back-to-back + CWF.
module tb_icache_line_fill;

    logic clk;
    logic rst;

    icache_line_fill_if #(.ADDR_W(32), .LINE_BITS(128)) bus ();

    icache_line_fill #(.ADDR_W(32), .LINE_BITS(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef LINE_FILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_fill   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.htrans[1] && bus.hready) n_acc <= n_acc + 1;
        if (bus.fill_valid) n_fill <= n_fill + 1;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] D0 = 32'h1111_AAA0, D1 = 32'h2222_BBB1,
                            D2 = 32'h3333_CCC2, D3 = 32'h4444_DDD3;
    localparam logic [31:0] E0 = 32'hE000_0000, E1 = 32'hE111_1111,
                            E2 = 32'hE222_2222, E3 = 32'hE333_3333;

    int acc0;
    int fill0;
    int nonseq;
    int second;

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.hready    = 1'b1;
        bus.hresp     = 1'b0;
        bus.hrdata    = '0;
        repeat (3) step();

        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_fill_valid", bus.fill_valid, 1'b0);
        check("rst_fill_err", bus.fill_err, 1'b0);
        check("rst_crit_valid", bus.crit_valid, 1'b0);
        check("rst_crit_data", bus.crit_data, 32'h0);
        check("rst_htrans", bus.htrans, 2'b00);
        check("rst_hburst", bus.hburst, 3'b000);
        check("rst_haddr", bus.haddr, 32'h0);
        check("rst_fill_line", bus.fill_line, 128'h0);
        check("rst_fill_addr", bus.fill_addr, 32'h0);
        check("rst_hsize", bus.hsize, 3'b010);
        check("rst_hwrite", bus.hwrite, 1'b0);
        rst = 1'b0;
        step();

        // Zero-wait fill from 0x1008: words 2,3,0,1 receive D0..D3.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_1008;
        check("t1_ready_T", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
        check("t1_trans_T1", bus.htrans, 2'b10);
        check("t1_addr_T1", bus.haddr, 32'h0000_1008);
        check("t1_burst_T1", bus.hburst, 3'b010);
        check("t1_ready_T1", bus.req_ready, 1'b0);
        step();
        check("t1_trans_T2", bus.htrans, 2'b11);
        check("t1_addr_T2", bus.haddr, 32'h0000_100C);
        bus.hrdata = D0;
        step();
        check("t1_addr_T3", bus.haddr, 32'h0000_1000);
        check("t1_crit_valid_T3", bus.crit_valid, CWF);
        check("t1_crit_data_T3", bus.crit_data, CWF ? D0 : 32'h0);
        bus.hrdata = D1;
        step();
        check("t1_addr_T4", bus.haddr, 32'h0000_1004);
        check("t1_crit_valid_T4", bus.crit_valid, 1'b0);
        bus.hrdata = D2;
        step();
        check("t1_trans_T5", bus.htrans, 2'b00);
        check("t1_burst_T5", bus.hburst, 3'b000);
        check("t1_fv_T5", bus.fill_valid, 1'b0);
        bus.hrdata = D3;
        step();
        check("t1_fv_T6", bus.fill_valid, 1'b1);
        check("t1_ferr_T6", bus.fill_err, 1'b0);
        check("t1_faddr_T6", bus.fill_addr, 32'h0000_1000);
        check("t1_line_T6", bus.fill_line, {D1, D0, D3, D2});
        check("t1_ready_T6", bus.req_ready, 1'b0);
        step();
        check("t1_fv_T7", bus.fill_valid, 1'b0);
        check("t1_ready_T7", bus.req_ready, 1'b1);
        check("t1_line_hold", bus.fill_line, {D1, D0, D3, D2});

        // Two wait states in the beat-1 data phase.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_2000;
        step();
        bus.req_valid = 1'b0;
        check("t2_addr_T1", bus.haddr, 32'h0000_2000);
        step();
        bus.hrdata = E0;
        step();
        check("t2_addr_T3", bus.haddr, 32'h0000_2008);
        bus.hready = 1'b0;
        bus.hrdata = 32'hDEAD_0001;
        step();
        check("t2_addr_T4", bus.haddr, 32'h0000_2008);
        check("t2_trans_T4", bus.htrans, 2'b11);
        step();
        check("t2_addr_T5", bus.haddr, 32'h0000_2008);
        check("t2_trans_T5", bus.htrans, 2'b11);
        bus.hready = 1'b1;
        bus.hrdata = E1;
        step();
        check("t2_addr_T6", bus.haddr, 32'h0000_200C);
        bus.hrdata = E2;
        step();
        check("t2_trans_T7", bus.htrans, 2'b00);
        check("t2_fv_T7", bus.fill_valid, 1'b0);
        bus.hrdata = E3;
        step();
        check("t2_fv_T8", bus.fill_valid, 1'b1);
        check("t2_faddr_T8", bus.fill_addr, 32'h0000_2000);
        check("t2_line_T8", bus.fill_line, {E3, E2, E1, E0});
        step();

        // ERROR during beat-2 data phase of a fill from 0x4004.
        acc0 = n_acc;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_4004;
        step();
        bus.req_valid = 1'b0;
        step();
        bus.hrdata = 32'h0A0A_0000;
        step();
        check("t3_addr_T3", bus.haddr, 32'h0000_400C);
        bus.hrdata = 32'h0A0A_0001;
        step();
        bus.hresp  = 1'b1;
        bus.hready = 1'b0;
        step();
        check("t3_trans_T5", bus.htrans, 2'b00);
        check("t3_fv_T5", bus.fill_valid, 1'b0);
        bus.hready = 1'b1;
        step();
        bus.hresp = 1'b0;
        check("t3_fv_T6", bus.fill_valid, 1'b1);
        check("t3_ferr_T6", bus.fill_err, 1'b1);
        check("t3_faddr_T6", bus.fill_addr, 32'h0000_4000);
        check("t3_accepted", n_acc - acc0, 3);
        step();
        check("t3_fv_T7", bus.fill_valid, 1'b0);
        check("t3_ferr_T7", bus.fill_err, 1'b0);
        check("t3_ready_T7", bus.req_ready, 1'b1);

        // Reset at T+3; the request's low address bits must be ignored.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_5003;
        step();
        bus.req_valid = 1'b0;
        check("t4_addr_T1", bus.haddr, 32'h0000_5000);
        step();
        bus.hrdata = 32'h5555_0000;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_trans_T4", bus.htrans, 2'b00);
        check("t4_ready_T4", bus.req_ready, 1'b1);
        check("t4_faddr_T4", bus.fill_addr, 32'h0);
        fill0 = n_fill;
        for (int i = 0; i < 8; i++) begin
            bus.hrdata = 32'hBAD0_0000 + 32'(i);
            step();
        end
        check("t4_no_fill", n_fill - fill0, 0);
        check("t4_line_clear", bus.fill_line, 128'h0);

        // req_valid held high: one burst per accept, second NONSEQ at T+8; CWF on the 0x300C fill.
        fill0  = n_fill;
        nonseq = 0;
        second = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_300C;
        bus.hrdata    = '0;
        check("t5_ready_T", bus.req_ready, 1'b1);
        for (int off = 1; off <= 14; off++) begin
            step();
            bus.hrdata = 32'hC0DE_0000 + 32'(off);
            if (bus.htrans == 2'b10) begin
                nonseq++;
                if (nonseq == 2) second = off;
            end
            if (off == 1) check("t5_addr_T1", bus.haddr, 32'h0000_300C);
            if (off == 2) check("t5_addr_wrap_T2", bus.haddr, 32'h0000_3000);
            if (off == 2) check("t5_crit_valid_T2", bus.crit_valid, 1'b0);
            if (off == 3) check("t5_crit_valid_T3", bus.crit_valid, CWF);
            if (off == 3) check("t5_crit_data_T3", bus.crit_data, CWF ? 32'hC0DE_0002 : 32'h0);
            if (off == 6) check("t5_fv_T6", bus.fill_valid, 1'b1);
            if (off == 6) check("t5_line_T6", bus.fill_line,
                                {32'hC0DE_0002, 32'hC0DE_0005, 32'hC0DE_0004, 32'hC0DE_0003});
            if (off == 6) check("t5_ready_T6", bus.req_ready, 1'b0);
            if (off == 7) check("t5_ready_T7", bus.req_ready, 1'b1);
            if (off == 13) check("t5_fv2_T13", bus.fill_valid, 1'b1);
        end
        bus.req_valid = 1'b0;
        check("t5_nonseq_count", nonseq, 2);
        check("t5_second_accept", second, 8);
        step();
        step();
        check("t5_fill_count", n_fill - fill0, 2);
        check("t5_idle_end", bus.htrans, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
